// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral with a small register map and a
// sample FIFO readable as a byte stream.
//
// Ports:
//   CLK, RST                  system clock, synchronous active-high reset
//   CS, SCLK, MOSI            SPI inputs (asynchronous to CLK)
//   MISO                      SPI data out, MSB first
//   X_DATA, Y_DATA, Z_DATA    live axis values at 0x08/0x09/0x0A
//   FIFO_WR, FIFO_DIN         sample FIFO push strobe and data
//   FIFO_FULL, FIFO_EMPTY     registered FIFO status
//   WR_VALID, WR_ADDR, WR_DATA one-CLK pulse per register byte written
//
// Instructions: 0x0B read, 0x0A write (both followed by an address byte,
// then a data burst with auto-incrementing pointer), 0x0D FIFO stream.
`timescale 1ns/1ps

module spi_peripheral #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CS,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic [7:0] X_DATA,
   input  logic [7:0] Y_DATA,
   input  logic [7:0] Z_DATA,
   input  logic       FIFO_WR,
   input  logic [7:0] FIFO_DIN,
   output logic       MISO,
   output logic       FIFO_FULL,
   output logic       FIFO_EMPTY,
   output logic       WR_VALID,
   output logic [7:0] WR_ADDR,
   output logic [7:0] WR_DATA
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INSTR,
      ST_ADDR,
      ST_RDATA,
      ST_WDATA,
      ST_FIFO,
      ST_IGNORE
   } state_t;

   // synchronizers and edge detection
   logic cs_m, cs_s, cs_d;
   logic sclk_m, sclk_s, sclk_d;
   logic mosi_m, mosi_s;

   // protocol state
   state_t      state;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift_in;
   logic [7:0]  addr_ptr;
   logic [7:0]  tx_sr;
   logic        op_write;
   logic [1:0]  settle;
   logic        armed;
   logic [7:0]  regs [16];

   // FIFO
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_next;
   logic          push_ok, pop_ok, pop_req;
   logic [7:0]    fifo_head;

   logic       sclk_rise, sclk_fall, cs_fall, byte_done;
   logic [7:0] rx_byte;
   logic [7:0] rd_addr, rd_byte;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cs_m   <= 1'b1;
         cs_s   <= 1'b1;
         cs_d   <= 1'b1;
         sclk_m <= 1'b0;
         sclk_s <= 1'b0;
         sclk_d <= 1'b0;
         mosi_m <= 1'b0;
         mosi_s <= 1'b0;
      end else begin
         cs_m   <= CS;
         cs_s   <= cs_m;
         cs_d   <= cs_s;
         sclk_m <= SCLK;
         sclk_s <= sclk_m;
         sclk_d <= sclk_s;
         mosi_m <= MOSI;
         mosi_s <= mosi_m;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = cs_d & ~cs_s;
   assign byte_done = sclk_rise & (bit_cnt == 3'd7);
   assign rx_byte   = {shift_in[6:0], mosi_s};

   // Address just received is used for the first read byte; the pointer after.
   always_comb begin
      rd_addr = (state == ST_ADDR) ? rx_byte : addr_ptr;
      rd_byte = '0;
      case (rd_addr)
         8'h00:   rd_byte = 8'hAD;
         8'h08:   rd_byte = X_DATA;
         8'h09:   rd_byte = Y_DATA;
         8'h0A:   rd_byte = Z_DATA;
         default: if (rd_addr[7:4] == 4'h2) rd_byte = regs[rd_addr[3:0]];
      endcase
   end

   assign pop_req = byte_done & ~cs_s &
                    (((state == ST_INSTR) && (rx_byte == 8'h0D)) || (state == ST_FIFO));
   assign pop_ok    = pop_req && (count != '0);
   assign push_ok   = FIFO_WR && ((count != CW'(FIFO_DEPTH)) || pop_ok);
   assign fifo_head = (count != '0) ? mem[rd_ptr] : '0;

   always_comb begin
      count_next = count;
      if (push_ok && !pop_ok)
         count_next = count + CW'(1);
      else if (!push_ok && pop_ok)
         count_next = count - CW'(1);
   end

   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr] <= FIFO_DIN;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         FIFO_FULL  <= 1'b0;
         FIFO_EMPTY <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
         count      <= count_next;
         FIFO_FULL  <= (count_next == CW'(FIFO_DEPTH));
         FIFO_EMPTY <= (count_next == '0);
      end
   end

   // After reset the CS synchronizer reads high regardless of the pin, so a
   // transaction is only accepted once CS has been genuinely seen high.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         bit_cnt  <= '0;
         shift_in <= '0;
         addr_ptr <= '0;
         tx_sr    <= '0;
         op_write <= 1'b0;
         settle   <= '0;
         armed    <= 1'b0;
         MISO     <= 1'b0;
         WR_VALID <= 1'b0;
         WR_ADDR  <= '0;
         WR_DATA  <= '0;
         for (int unsigned i = 0; i < 16; i++)
            regs[i] <= '0;
      end else begin
         WR_VALID <= 1'b0;
         if (settle != 2'd2)
            settle <= settle + 2'd1;
         else if (cs_s)
            armed <= 1'b1;

         if (cs_s) begin
            state <= ST_IDLE;
            MISO  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  MISO <= 1'b0;
                  if (armed && cs_fall) begin
                     state   <= ST_INSTR;
                     bit_cnt <= '0;
                  end
               end
               default: begin
                  if (sclk_rise) begin
                     shift_in <= rx_byte;
                     bit_cnt  <= bit_cnt + 3'd1;
                  end
                  if (byte_done) begin
                     case (state)
                        ST_INSTR: begin
                           case (rx_byte)
                              8'h0B: begin
                                 state    <= ST_ADDR;
                                 op_write <= 1'b0;
                              end
                              8'h0A: begin
                                 state    <= ST_ADDR;
                                 op_write <= 1'b1;
                              end
                              8'h0D: begin
                                 state <= ST_FIFO;
                                 tx_sr <= fifo_head;
                              end
                              default: state <= ST_IGNORE;
                           endcase
                        end
                        ST_ADDR: begin
                           if (op_write) begin
                              state    <= ST_WDATA;
                              addr_ptr <= rx_byte;
                           end else begin
                              state    <= ST_RDATA;
                              tx_sr    <= rd_byte;
                              addr_ptr <= rx_byte + 8'd1;
                           end
                        end
                        ST_RDATA: begin
                           tx_sr    <= rd_byte;
                           addr_ptr <= addr_ptr + 8'd1;
                        end
                        ST_WDATA: begin
                           if (addr_ptr[7:4] == 4'h2)
                              regs[addr_ptr[3:0]] <= rx_byte;
                           WR_VALID <= 1'b1;
                           WR_ADDR  <= addr_ptr;
                           WR_DATA  <= rx_byte;
                           addr_ptr <= addr_ptr + 8'd1;
                        end
                        ST_FIFO: tx_sr <= fifo_head;
                        default: ;
                     endcase
                  end
                  if ((state == ST_RDATA) || (state == ST_FIFO)) begin
                     if (sclk_fall) begin
                        MISO  <= tx_sr[7];
                        tx_sr <= {tx_sr[6:0], 1'b0};
                     end
                  end else begin
                     MISO <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps

module tb_spi_peripheral;

   localparam int HALF = 60;   // SCLK half period = 6 CLK

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CS = 1'b1;
   logic       SCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic [7:0] X_DATA = '0, Y_DATA = '0, Z_DATA = '0;
   logic       FIFO_WR = 1'b0;
   logic [7:0] FIFO_DIN = '0;
   logic       MISO, FIFO_FULL, FIFO_EMPTY, WR_VALID;
   logic [7:0] WR_ADDR, WR_DATA;

   int checks = 0;
   int errors = 0;

   logic [15:0] wr_q[$];
   logic        watch_full = 1'b0;
   logic        full_dropped = 1'b0;

   spi_peripheral #(.FIFO_DEPTH(8)) dut (
      .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
      .X_DATA(X_DATA), .Y_DATA(Y_DATA), .Z_DATA(Z_DATA),
      .FIFO_WR(FIFO_WR), .FIFO_DIN(FIFO_DIN),
      .MISO(MISO), .FIFO_FULL(FIFO_FULL), .FIFO_EMPTY(FIFO_EMPTY),
      .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (WR_VALID === 1'b1) wr_q.push_back({WR_ADDR, WR_DATA});
      if (watch_full && FIFO_FULL !== 1'b1) full_dropped = 1'b1;
   end

   task automatic spi_bits(input logic [7:0] tx, input int unsigned n, output logic [7:0] rx);
      rx = '0;
      for (int unsigned i = 0; i < n; i++) begin
         MOSI = tx[7-i];
         #(HALF);
         rx = {rx[6:0], MISO};
         SCLK = 1'b1;
         #(HALF);
         SCLK = 1'b0;
      end
   endtask

   task automatic cs_begin();
      CS = 1'b0;
      #(HALF);
   endtask

   task automatic cs_end();
      #(HALF);
      CS = 1'b1;
      #(2*HALF);
   endtask

   task automatic push(input logic [7:0] v);
      @(posedge CLK); #1;
      FIFO_WR = 1'b1;
      FIFO_DIN = v;
      @(posedge CLK); #1;
      FIFO_WR = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (5) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got=%b exp=0", MISO); end
      checks++; if (WR_VALID !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", WR_VALID); end
      checks++; if (WR_ADDR !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got=%h exp=00", WR_ADDR); end
      checks++; if (WR_DATA !== 8'h00) begin errors++; $display("FAIL reset_wr_data got=%h exp=00", WR_DATA); end
      checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_fifo_empty got=%b exp=1", FIFO_EMPTY); end
      checks++; if (FIFO_FULL !== 1'b0) begin errors++; $display("FAIL reset_fifo_full got=%b exp=0", FIFO_FULL); end
   endtask

   task automatic test_read_id();
      logic [7:0] rx;
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL read_id got=%h exp=ad", rx); end
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL read_addr01 got=%h exp=00", rx); end
      cs_end();
      checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL idle_miso got=%b exp=0", MISO); end
   endtask

   task automatic test_write();
      logic [7:0]  rx;
      logic [15:0] got;
      wr_q.delete();
      cs_begin();
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h5A, 8, rx);
      spi_bits(8'hC3, 8, rx);
      cs_end();
      checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL write_pulses got=%0d exp=2", wr_q.size()); end
      got = (wr_q.size() > 0) ? wr_q[0] : 16'hFFFF;
      checks++; if (got !== 16'h205A) begin errors++; $display("FAIL write_first got=%h exp=205a", got); end
      got = (wr_q.size() > 1) ? wr_q[1] : 16'hFFFF;
      checks++; if (got !== 16'h21C3) begin errors++; $display("FAIL write_second got=%h exp=21c3", got); end
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL readback_20 got=%h exp=5a", rx); end
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL readback_21 got=%h exp=c3", rx); end
      cs_end();
   endtask

   task automatic test_axis();
      logic [7:0] rx;
      logic [7:0] exp_axis [3] = '{8'h12, 8'h34, 8'h56};
      X_DATA = 8'h12; Y_DATA = 8'h34; Z_DATA = 8'h56;
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h08, 8, rx);
      for (int i = 0; i < 3; i++) begin
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== exp_axis[i]) begin errors++; $display("FAIL axis_%0d got=%h exp=%h", i, rx, exp_axis[i]); end
      end
      cs_end();
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'hFF, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL read_ff got=%h exp=00", rx); end
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'hAD) begin errors++; $display("FAIL wrap_00 got=%h exp=ad", rx); end
      cs_end();
   endtask

   task automatic test_fifo();
      logic [7:0] rx;
      logic [7:0] exp_f [3] = '{8'h11, 8'h22, 8'h00};
      push(8'h11);
      push(8'h22);
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (FIFO_EMPTY !== 1'b0) begin errors++; $display("FAIL fifo_not_empty got=%b exp=0", FIFO_EMPTY); end
      cs_begin();
      spi_bits(8'h0D, 8, rx);
      for (int i = 0; i < 3; i++) begin
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== exp_f[i]) begin errors++; $display("FAIL fifo_byte_%0d got=%h exp=%h", i, rx, exp_f[i]); end
      end
      cs_end();
      checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL fifo_empty_after got=%b exp=1", FIFO_EMPTY); end
   endtask

   task automatic test_fifo_full();
      logic [7:0] rx;
      logic [7:0] exp_v;
      for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (FIFO_FULL !== 1'b1) begin errors++; $display("FAIL fifo_full got=%b exp=1", FIFO_FULL); end
      // hold a push across the pop caused by the 0x0D instruction
      cs_begin();
      FIFO_DIN = 8'h99;
      FIFO_WR = 1'b1;
      full_dropped = 1'b0;
      watch_full = 1'b1;
      spi_bits(8'h0D, 8, rx);
      FIFO_WR = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      watch_full = 1'b0;
      checks++; if (full_dropped !== 1'b0) begin errors++; $display("FAIL full_during_push_pop got=%b exp=0", full_dropped); end
      checks++; if (FIFO_FULL !== 1'b1) begin errors++; $display("FAIL full_after_push_pop got=%b exp=1", FIFO_FULL); end
      for (int i = 0; i < 9; i++) begin
         exp_v = (i < 8) ? 8'hA0 + 8'(i) : 8'h99;
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== exp_v) begin errors++; $display("FAIL full_stream_%0d got=%h exp=%h", i, rx, exp_v); end
      end
      cs_end();
      checks++; if (FIFO_EMPTY !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", FIFO_EMPTY); end
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      logic [7:0] acc;
      wr_q.delete();
      cs_begin();
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h21, 8, rx);
      spi_bits(8'hFF, 4, rx);
      cs_end();
      checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL abort_no_write got=%0d exp=0", wr_q.size()); end
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h21, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'hC3) begin errors++; $display("FAIL abort_reg_kept got=%h exp=c3", rx); end
      cs_end();
      acc = '0;
      cs_begin();
      spi_bits(8'h55, 8, rx);
      acc |= rx;
      spi_bits(8'h20, 8, rx);
      acc |= rx;
      spi_bits(8'hFF, 8, rx);
      acc |= rx;
      cs_end();
      checks++; if (acc !== 8'h00) begin errors++; $display("FAIL ignore_miso got=%h exp=00", acc); end
      checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ignore_no_write got=%0d exp=0", wr_q.size()); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      wr_q.delete();
      cs_begin();
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h22, 8, rx);
      spi_bits(8'h77, 4, rx);
      @(posedge CLK); #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      #(HALF);
      // CS stays low: the remaining bits must not form a transaction
      spi_bits(8'h77, 4, rx);
      spi_bits(8'h0A, 8, rx);
      spi_bits(8'h22, 8, rx);
      spi_bits(8'h66, 8, rx);
      cs_end();
      checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL reset_mid_no_write got=%0d exp=0", wr_q.size()); end
      cs_begin();
      spi_bits(8'h0B, 8, rx);
      spi_bits(8'h20, 8, rx);
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reset_clears_20 got=%h exp=00", rx); end
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reset_clears_21 got=%h exp=00", rx); end
      spi_bits(8'h00, 8, rx);
      checks++; if (rx !== 8'h00) begin errors++; $display("FAIL reset_mid_22 got=%h exp=00", rx); end
      cs_end();
   endtask

   initial begin
      #2;
      test_reset();
      test_read_id();
      test_write();
      test_axis();
      test_fifo();
      test_fifo_full();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_peripheral.md
SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of 8-bit entries in the sample FIFO (power of 2).
REQ-002 CLK  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CS  input  1  SPI chip select, active low, asynchronous to CLK.
REQ-005 SCLK  input  1  SPI clock, mode 0, asynchronous to CLK.
REQ-006 MOSI  input  1  SPI data from controller, MSB first.
REQ-007 X_DATA, Y_DATA, Z_DATA  input  8 each  live axis values, exposed at register addresses 0x08, 0x09 and 0x0A respectively.
REQ-008 FIFO_WR  input  1  push strobe for the sample FIFO.
REQ-009 FIFO_DIN  input  8  sample FIFO write data.
REQ-010 MISO  output  1  SPI data to controller, MSB first.
REQ-011 FIFO_FULL, FIFO_EMPTY  output  1 each  sample FIFO status flags.
REQ-012 WR_VALID  output  1  one-CLK pulse per register byte written.
REQ-013 WR_ADDR  output  8  address of the byte written; WR_DATA  output  8  data of the byte written.

Function
REQ-014 CS, SCLK and MOSI SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected on the synchronized signal; SCLK period is guaranteed ≥ 8 CLK.
REQ-015 States: IDLE, INSTR, ADDR, RDATA, WDATA, FIFO, IGNORE.
REQ-016 IDLE -> INSTR on synchronized CS falling; a synchronized CS high in any state SHALL force IDLE on the next CLK, discarding any partial byte.
REQ-017 MOSI SHALL be sampled on each detected SCLK rising edge; the bit counter SHALL reset to 0 on entry to INSTR.
REQ-018 After the 8th instruction bit: 0x0B -> ADDR (read), 0x0A -> ADDR (write), 0x0D -> FIFO, any other value -> IGNORE until CS high.
REQ-019 After the 8th address bit: ADDR -> RDATA for a read, ADDR -> WDATA for a write; the address pointer SHALL load the received byte.
REQ-020 Register map:
- 0x00 = 0xAD, read-only.
- 0x08/0x09/0x0A = X/Y/Z_DATA, read-only, sampled when the byte is loaded.
- 0x20-0x2F = 16 read/write bytes, reset 0x00.
- All other addresses read 0x00; writes to them are ignored.
REQ-021 RDATA: on the SCLK rising edge that completes the address byte (or the previous data byte), the byte at the address pointer SHALL be loaded into the TX shift register and the pointer incremented.
REQ-022 MISO SHALL present the loaded MSB at the next SCLK falling edge and shift one bit per subsequent falling edge.
REQ-023 WDATA: each completed byte SHALL update a writable register at the pointer, pulse WR_VALID for one CLK with WR_ADDR/WR_DATA set (the pulse occurs even for ignored addresses), then increment the pointer.
REQ-024 The address pointer SHALL wrap 0xFF -> 0x00.
REQ-025 FIFO state: each byte load SHALL pop the FIFO head into the TX shift register. Pop while empty SHALL load 0x00 and leave the pointers unchanged.
REQ-026 FIFO_WR while full SHALL be dropped. A simultaneous push and pop SHALL both occur, with occupancy unchanged; this includes when full.
REQ-027 FIFO_FULL/FIFO_EMPTY SHALL be registered and reflect occupancy one CLK after the update.
REQ-028 MISO SHALL be 0 in IDLE, INSTR, ADDR, WDATA and IGNORE.
REQ-029 Latency: MISO change ≤ 4 CLK after a physical SCLK falling edge; WR_VALID ≤ 4 CLK after the 8th data rising edge.

Reset
REQ-030 On RST: state IDLE, MISO 0, WR_VALID 0, WR_ADDR 0x00, WR_DATA 0x00, registers 0x20-0x2F = 0x00, FIFO emptied (FIFO_EMPTY 1, FIFO_FULL 0), synchronizers cleared to CS=1, SCLK=0, MOSI=0.
REQ-031 RST asserted mid-transaction SHALL abort it; after RST release the block SHALL wait for a fresh CS falling edge before accepting a new transaction.

Verification
REQ-032 Read 0x0B,0x00 -> MISO returns 0xAD; extend one byte -> 0x00 (addr 0x01).
REQ-033 Write 0x0A,0x20,0x5A,0xC3 -> WR_VALID pulses twice with (0x20,0x5A) and (0x21,0xC3); read back 0x0B,0x20 -> 0x5A,0xC3.
REQ-034 X_DATA=0x12, Y_DATA=0x34, Z_DATA=0x56; burst read from 0x08 -> 0x12,0x34,0x56; burst read from 0xFF -> 0x00 then 0xAD (wrap).
REQ-035 Push 0x11,0x22; FIFO read 0x0D plus 3 bytes -> 0x11,0x22,0x00; FIFO_EMPTY=1 afterwards.
REQ-036 Push 9 bytes with FIFO_DEPTH=8 -> FIFO_FULL=1, 9th dropped; a simultaneous push and pop while full leaves FIFO_FULL=1.
REQ-037 CS raised after 4 data bits of a write to 0x21 -> no WR_VALID, register unchanged; instruction 0x55 -> MISO 0, no writes.
